// File: rtl/mux_scan_pkg.sv
// Shared types and default sizing for the mux scan sequencer.
package mux_scan_pkg;

  localparam int unsigned N_DEF     = 8;
  localparam int unsigned SEL_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } scan_state_t;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Start / mux / result handshake bundle of the mux scan sequencer.
// out_parity exists only when MUX_SCAN_SEQ_PARITY_EN is defined.
interface mux_scan_sequencer_if
  import mux_scan_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
) ();

  logic             start_valid;
  logic             start_ready;
  logic             abort;
  logic [SEL_W-1:0] mux_sel;
  logic             mux_out;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
`ifdef MUX_SCAN_SEQ_PARITY_EN
  logic             out_parity;
`endif

  // Sequencer side
  modport master (
    input  start_valid, abort, mux_out, out_ready,
`ifdef MUX_SCAN_SEQ_PARITY_EN
    output out_parity,
`endif
    output start_ready, mux_sel, out_valid, out_data
  );

  // Requester / mux / consumer side
  modport slave (
    output start_valid, abort, mux_out, out_ready,
`ifdef MUX_SCAN_SEQ_PARITY_EN
    input  out_parity,
`endif
    input  start_ready, mux_sel, out_valid, out_data
  );

endinterface

// File: rtl/mux_scan_sequencer_scan_sel_counter.sv
// Mux select counter: clear to zero, increment or hold; flags the last index.
module scan_sel_counter #(
  parameter int unsigned N     = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [SEL_W-1:0] sel,
  output logic             tc_c
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= '0;
    end else if (clr) begin
      sel <= '0;
    end else if (inc) begin
      sel <= sel + SEL_W'(1);
    end
  end

  assign tc_c = (sel == LAST);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps an external 8:1 mux through all inputs and reassembles the samples
// into a parallel word with a valid/ready result. Option: MUX_SCAN_SEQ_PARITY_EN.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  mux_scan_sequencer_if.master bus
);

  scan_state_t  state, state_nxt;
  logic [N-1:0] shadow, shadow_nxt;
  logic [N-1:0] data_nxt;
  logic         valid_nxt;
  logic         ready_nxt;
  logic         cnt_clr;
  logic         cnt_inc;
  logic         sel_tc_c;

  scan_sel_counter #(.N(N), .SEL_W(SEL_W)) u_sel_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .sel   (bus.mux_sel),
    .tc_c  (sel_tc_c)
  );

  // Next state; abort outranks every other transition outside IDLE
  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    data_nxt   = bus.out_data;
    valid_nxt  = bus.out_valid;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start_valid && !bus.abort) begin
          state_nxt  = SCAN;
          shadow_nxt = '0;
          cnt_clr    = 1'b1;
        end
      end
      SCAN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          cnt_clr   = 1'b1;
        end else begin
          shadow_nxt[bus.mux_sel] = bus.mux_out;
          if (sel_tc_c) begin
            state_nxt = HOLD;
            data_nxt  = shadow_nxt;
            valid_nxt = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          cnt_clr   = 1'b1;
        end else if (bus.out_ready) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        cnt_clr   = 1'b1;
      end
    endcase
    ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      shadow          <= '0;
      bus.out_data    <= '0;
      bus.out_valid   <= 1'b0;
      bus.start_ready <= 1'b1;
    end else begin
      state           <= state_nxt;
      shadow          <= shadow_nxt;
      bus.out_data    <= data_nxt;
      bus.out_valid   <= valid_nxt;
      bus.start_ready <= ready_nxt;
    end
  end

`ifdef MUX_SCAN_SEQ_PARITY_EN
  // Even parity tracks out_data, so it only moves on a completion edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_parity <= 1'b0;
    end else begin
      bus.out_parity <= ^data_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomized self-checking bench for mux_scan_sequencer with an index-based
// pass model and a combinational 8:1 mux model on mux_sel / mux_out.
module tb_mux_scan_sequencer;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mux_in = 8'h00;

  mux_scan_sequencer_if #(.N(8), .SEL_W(3)) bus ();

  mux_scan_sequencer #(.N(8), .SEL_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.mux_out = mux_in[bus.mux_sel];

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model: ph = -1 idle, 0..N-1 index being sampled, N waiting for consumer
  int         ph = -1;
  logic [2:0] exp_sel = 3'd0;
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic [7:0] m_shadow = 8'h00;
  int         acc_last = 0;
  int         acc_q[$];
  logic [7:0] res_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge rst_n) begin
    ph        = -1;
    exp_sel   = 3'd0;
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    m_shadow  = 8'h00;
  end

  // Model step on each active edge, then compare every output just after it
  always @(posedge clk) begin
    if (rst_n) begin
      cyc++;
      if (ph >= 0 && bus.abort) begin
        ph        = -1;
        exp_sel   = 3'd0;
        exp_valid = 1'b0;
      end else if (ph < 0) begin
        if (bus.start_valid && !bus.abort) begin
          ph       = 0;
          exp_sel  = 3'd0;
          m_shadow = 8'h00;
          acc_last = cyc;
          acc_q.push_back(cyc);
        end
      end else if (ph < N) begin
        m_shadow[ph] = mux_in[ph];
        if (ph == N - 1) begin
          exp_data  = m_shadow;
          exp_valid = 1'b1;
          ph        = N;
        end else begin
          ph++;
          exp_sel = 3'(ph);
        end
      end else if (bus.out_ready) begin
        res_q.push_back(exp_data);
        ph        = -1;
        exp_valid = 1'b0;
      end
    end
    #1;
    if (rst_n) begin
      check("start_ready", 32'(bus.start_ready), 32'(ph < 0));
      check("mux_sel", 32'(bus.mux_sel), 32'(exp_sel));
      check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      check("out_data", 32'(bus.out_data), 32'(exp_data));
`ifdef MUX_SCAN_SEQ_PARITY_EN
      check("out_parity", 32'(bus.out_parity), 32'(^exp_data));
`endif
    end
  end

  task automatic wait_sel(input logic [2:0] s);
    int t = 0;
    while (bus.mux_sel !== s && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("wait_sel", 32'(bus.mux_sel), 32'(s));
  endtask

  // One pass with constant input, consumer stalled for 'hold' cycles
  task automatic run_pass(input logic [7:0] in, input int hold);
    int t = 0;
    mux_in = in;
    bus.start_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start_valid = 1'b0;
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("valid_rise", 32'(bus.out_valid), 32'd1);
    check("latency", 32'(cyc - acc_last), 32'd8);
    check("pass_data", 32'(bus.out_data), 32'(in));
`ifdef MUX_SCAN_SEQ_PARITY_EN
    check("pass_parity", 32'(bus.out_parity), 32'(^in));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", 32'(bus.out_data), 32'(in));
      check("hold_start_ready", 32'(bus.start_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("idle_after_ready", 32'(bus.start_ready), 32'd1);
    check("valid_cleared", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, r0, t;
    bus.start_valid = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start_ready", 32'(bus.start_ready), 32'd1);
    check("rst_mux_sel", 32'(bus.mux_sel), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic pass and back-pressure
    run_pass(8'hA5, 0);
    check("basic_literal", 32'(exp_data), 32'hA5);
    run_pass(8'h3C, 5);

    // Abort mid-pass keeps the previous result
    mux_in = 8'h5A;
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    wait_sel(3'd4);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_idle", 32'(bus.start_ready), 32'd1);
    check("abort_sel", 32'(bus.mux_sel), 32'd0);
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_data", 32'(bus.out_data), 32'h3C);

    // Abort in IDLE blocks the start that cycle
    bus.abort = 1'b1;
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start_valid = 1'b0;
    @(negedge clk);
    check("idle_abort_ready", 32'(bus.start_ready), 32'd1);
    check("idle_abort_sel", 32'(bus.mux_sel), 32'd0);

    // Asynchronous reset mid-pass
    mux_in = 8'hC3;
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    wait_sel(3'd6);
    rst_n = 1'b0;
    #1;
    check("arst_sel", 32'(bus.mux_sel), 32'd0);
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_data", 32'(bus.out_data), 32'd0);
    check("arst_start_ready", 32'(bus.start_ready), 32'd1);
`ifdef MUX_SCAN_SEQ_PARITY_EN
    check("arst_parity", 32'(bus.out_parity), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_pass(8'hFF, 1);
`ifdef MUX_SCAN_SEQ_PARITY_EN
    check("ff_parity_literal", 32'(bus.out_parity), 32'd0);
`endif

    // Back-to-back passes with consumer always ready
    a0 = acc_q.size();
    r0 = res_q.size();
    bus.out_ready = 1'b1;
    mux_in = 8'h01;
    bus.start_valid = 1'b1;
    t = 0;
    while (!bus.out_valid && t < 30) begin
      @(negedge clk);
      t++;
    end
    mux_in = 8'h80;
    t = 0;
    while (acc_q.size() < a0 + 2 && t < 30) begin
      @(negedge clk);
      t++;
    end
    bus.start_valid = 1'b0;
    t = 0;
    while (res_q.size() < r0 + 2 && t < 30) begin
      @(negedge clk);
      t++;
    end
    bus.out_ready = 1'b0;
    check("b2b_count", 32'(res_q.size() - r0), 32'd2);
    if (res_q.size() >= r0 + 2 && acc_q.size() >= a0 + 2) begin
      check("b2b_first", 32'(res_q[r0]), 32'h01);
      check("b2b_second", 32'(res_q[r0+1]), 32'h80);
      check("b2b_spacing", 32'(acc_q[a0+1] - acc_q[a0]), 32'd10);
    end
    @(negedge clk);

    // Odd-parity input
    run_pass(8'h07, 1);
    check("p07_data_literal", 32'(exp_data), 32'h07);
`ifdef MUX_SCAN_SEQ_PARITY_EN
    check("p07_parity_literal", 32'(bus.out_parity), 32'd1);
`endif

    // Randomized traffic, including input changes mid-pass
    r0 = res_q.size();
    repeat (1500) begin
      @(negedge clk);
      bus.start_valid = 1'($urandom_range(0, 1));
      bus.abort = ($urandom_range(0, 24) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) mux_in = 8'($urandom);
    end
    bus.start_valid = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    check("random_progress", 32'(res_q.size() > r0 + 20), 32'd1);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
